// File: rtl/bopit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bopit_pkg : result codes and state encoding shared by the game blocks
// Rev 1.0
// ----------------------------------------------------------------------------
package bopit_pkg;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_HIT     = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;
    localparam logic [1:0] RES_MISS    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bopit_round_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bopit_round_timer : per-round reaction window with hit/miss/timeout outcome
//                     and a saturating score counter
// Rev 1.0
// ----------------------------------------------------------------------------
module bopit_round_timer
    import bopit_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [CNT_W-1:0]   limit,
    input  logic               hit,
    input  logic               miss,
    input  logic               clear_score,
    output logic               busy,
    output logic [CNT_W-1:0]   remaining,
    output logic               done,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] score
);

    state_t             r_state,     w_state_nx;
    logic [CNT_W-1:0]   r_remaining, w_remaining_nx;
    logic [1:0]         r_result,    w_result_nx;
    logic [SCORE_W-1:0] r_score,     w_score_nx;
    logic               r_busy;
    logic               r_done;
    logic               w_scoring;

    always_comb begin
        w_state_nx     = r_state;
        w_remaining_nx = r_remaining;
        w_result_nx    = r_result;
        w_scoring      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_remaining_nx = limit;
                    if (limit == '0) begin
                        w_result_nx = RES_TIMEOUT;
                        w_state_nx  = ST_DONE;
                    end else begin
                        w_result_nx = RES_NONE;
                        w_state_nx  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // hit outranks miss, which outranks the tick of the same cycle
                if (hit) begin
                    w_result_nx = RES_HIT;
                    w_scoring   = 1'b1;
                    w_state_nx  = ST_DONE;
                end else if (miss) begin
                    w_result_nx = RES_MISS;
                    w_state_nx  = ST_DONE;
                end else if (tick) begin
                    w_remaining_nx = r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        w_result_nx = RES_TIMEOUT;
                        w_state_nx  = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase

        w_score_nx = r_score;
        if (clear_score) begin
            w_score_nx = '0;
        end else if (w_scoring && (r_score != '1)) begin
            w_score_nx = r_score + SCORE_W'(1);
        end
    end

    // busy/done are registered from the next state so outputs stay flop-driven
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_result    <= RES_NONE;
            r_score     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_remaining <= w_remaining_nx;
            r_result    <= w_result_nx;
            r_score     <= w_score_nx;
            r_busy      <= (w_state_nx == ST_RUN);
            r_done      <= (w_state_nx == ST_DONE);
        end
    end

    assign busy      = r_busy;
    assign remaining = r_remaining;
    assign done      = r_done;
    assign result    = r_result;
    assign score     = r_score;

endmodule
`default_nettype wire

// File: tb/tb_bopit_round_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bopit_round_timer : directed vectors for bopit_round_timer (SCORE_W=2)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_bopit_round_timer;

    localparam int CNT_W   = 8;
    localparam int SCORE_W = 2;

    logic               clk;
    logic               reset;
    logic               tick;
    logic               start;
    logic [CNT_W-1:0]   limit;
    logic               hit;
    logic               miss;
    logic               clear_score;
    logic               busy;
    logic [CNT_W-1:0]   remaining;
    logic               done;
    logic [1:0]         result;
    logic [SCORE_W-1:0] score;

    int n_vec;
    int n_bad;

    bopit_round_timer #(.CNT_W(CNT_W), .SCORE_W(SCORE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .limit       (limit),
        .hit         (hit),
        .miss        (miss),
        .clear_score (clear_score),
        .busy        (busy),
        .remaining   (remaining),
        .done        (done),
        .result      (result),
        .score       (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] lim);
        limit = lim;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        tick = 1'b0; start = 1'b0; limit = '0;
        hit = 1'b0; miss = 1'b0; clear_score = 1'b0;
        cycle(); cycle();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_rem", 32'(remaining), 32'd0);
        check_val("rst_res", 32'(result), 32'd0);
        check_val("rst_score", 32'(score), 32'd0);
        reset = 1'b0;
        cycle();

        // Timeout: limit 3, ticks spaced 10 cycles apart
        do_start(8'd3);
        check_val("to_busy", 32'(busy), 32'd1);
        check_val("to_rem0", 32'(remaining), 32'd3);
        for (int k = 1; k <= 3; k++) begin
            repeat (9) cycle();
            do_tick();
            check_val("to_rem", 32'(remaining), 32'(3 - k));
        end
        check_val("to_done", 32'(done), 32'd1);
        check_val("to_res", 32'(result), 32'd2);
        check_val("to_busy_end", 32'(busy), 32'd0);
        check_val("to_score", 32'(score), 32'd0);
        cycle();
        check_val("to_done_1cyc", 32'(done), 32'd0);

        // Hit colliding with a tick
        do_start(8'd5);
        do_tick(); do_tick();
        hit = 1'b1; tick = 1'b1;
        cycle();
        hit = 1'b0; tick = 1'b0;
        check_val("hc_res", 32'(result), 32'd1);
        check_val("hc_rem", 32'(remaining), 32'd3);
        check_val("hc_score", 32'(score), 32'd1);
        check_val("hc_done", 32'(done), 32'd1);
        cycle();
        check_val("hc_done_1cyc", 32'(done), 32'd0);

        // Miss alone
        do_start(8'd5);
        check_val("ms_res_clr", 32'(result), 32'd0);
        miss = 1'b1; cycle(); miss = 1'b0;
        check_val("ms_res", 32'(result), 32'd3);
        check_val("ms_score", 32'(score), 32'd1);
        cycle();

        // Hit and miss together
        do_start(8'd5);
        hit = 1'b1; miss = 1'b1; cycle(); hit = 1'b0; miss = 1'b0;
        check_val("hm_res", 32'(result), 32'd1);
        check_val("hm_score", 32'(score), 32'd2);
        cycle();

        // Start while running does not reload
        do_start(8'd5);
        do_tick(); do_tick();
        do_start(8'd4);
        check_val("ig_rem", 32'(remaining), 32'd3);
        check_val("ig_busy", 32'(busy), 32'd1);
        miss = 1'b1; cycle(); miss = 1'b0;
        check_val("ig_res", 32'(result), 32'd3);
        cycle();

        // Zero limit
        do_start(8'd0);
        check_val("z_done", 32'(done), 32'd1);
        check_val("z_res", 32'(result), 32'd2);
        check_val("z_busy", 32'(busy), 32'd0);
        cycle();
        check_val("z_done_1cyc", 32'(done), 32'd0);
        check_val("z_busy2", 32'(busy), 32'd0);

        // Saturation: score is 2, three more hits stay at 3
        for (int r = 0; r < 3; r++) begin
            do_start(8'd7);
            hit = 1'b1; cycle(); hit = 1'b0;
            check_val("sat_score", 32'(score), 32'd3);
            cycle();
        end

        // Clear coinciding with a hit
        do_start(8'd7);
        hit = 1'b1; clear_score = 1'b1; cycle(); hit = 1'b0; clear_score = 1'b0;
        check_val("clr_score", 32'(score), 32'd0);
        check_val("clr_res", 32'(result), 32'd1);
        cycle();

        // Asynchronous reset with remaining = 2
        do_start(8'd5);
        do_tick(); do_tick(); do_tick();
        check_val("ar_pre_rem", 32'(remaining), 32'd2);
        #2 reset = 1'b1;
        #1;
        check_val("ar_busy", 32'(busy), 32'd0);
        check_val("ar_rem", 32'(remaining), 32'd0);
        check_val("ar_res", 32'(result), 32'd0);
        check_val("ar_done", 32'(done), 32'd0);
        cycle();
        check_val("ar_done_edge", 32'(done), 32'd0);
        reset = 1'b0;
        cycle();
        check_val("ar_idle_done", 32'(done), 32'd0);
        do_start(8'd2);
        check_val("ar_new_busy", 32'(busy), 32'd1);
        do_tick();
        check_val("ar_new_rem", 32'(remaining), 32'd1);
        do_tick();
        check_val("ar_new_done", 32'(done), 32'd1);
        check_val("ar_new_res", 32'(result), 32'd2);
        check_val("ar_new_rem0", 32'(remaining), 32'd0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
